// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU controller and a big-endian, word-port data memory.
// Optional macro MAU_RANGE_CHECK_EN: flag accesses beyond MEM_BYTES as errors instead of wrapping.
module mem_access_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rw,
  input  logic [31:0]       mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // RD    | memory word being read (load, or first half of read-modify-write)
  // WR    | mem_rw high for this single cycle
  // DONE  | resp_valid pulse, response registers already updated
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state, state_n;

  logic              wr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;

  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        req_off;
  logic              align_err;
  logic              range_err;
  logic              req_err;
  logic              word_store;

  assign waddr      = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_off    = req_addr[1:0];
  assign word_store = req_write && (req_size == 2'b10);

  always_comb begin
    align_err = 1'b0;
    case (req_size)
      2'b01:   align_err = req_off[0];
      2'b10:   align_err = (req_off != 2'b00);
      2'b11:   align_err = 1'b1;
      default: align_err = 1'b0;
    endcase
  end

`ifdef MAU_RANGE_CHECK_EN
  logic [ADDR_W:0] waddr_top;
  assign waddr_top = {1'b0, waddr} + (ADDR_W+1)'(3);
  assign range_err = (waddr_top >= (ADDR_W+1)'(MEM_BYTES));
  assign bus_addr  = waddr;
`else
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);
  // Out-of-range addresses wrap onto the physical memory.
  assign range_err = 1'b0;
  assign bus_addr  = waddr & ADDR_MASK;
`endif

  assign req_err = align_err | range_err;

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] off, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (size == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d;
    end else begin
      r[31:16] = d;
    end
    return r;
  endfunction

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)         state_n = DONE;
          else if (word_store) state_n = WR;
          else                 state_n = RD;
        end
      end
      RD:      state_n = wr_q ? WR : DONE;
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);

  // mem_addr/mem_wdata only move on edges entering RD or WR, never when mem_rw falls,
  // because the memory writes on any input change while mem_rw is high.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= 16'h0000;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0000_0000;
      mem_rw     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            off_q   <= req_off;
            wdata_q <= req_wdata[15:0];
            if (req_err) begin
              resp_rdata <= 32'h0000_0000;
              resp_err   <= 1'b1;
            end else begin
              mem_addr <= bus_addr;
              if (word_store) begin
                mem_wdata <= req_wdata;
                mem_rw    <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (wr_q) begin
            mem_wdata <= lane_merge(mem_rdata, size_q, off_q, wdata_q);
            mem_rw    <= 1'b1;
          end else begin
            resp_rdata <= lane_extract(mem_rdata, size_q, off_q, sgn_q);
            resp_err   <= 1'b0;
          end
        end
        WR: begin
          mem_rw     <= 1'b0;
          resp_rdata <= 32'h0000_0000;
          resp_err   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model plus
// per-cycle compare, directed cases with literal expectations, then random traffic.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 64;
  localparam int ADDR_W    = 32;
  localparam int NW        = MEM_BYTES / 4;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rw;
  logic [31:0]       mem_rdata;

  always #5 CLK = ~CLK;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  // Data memory seen by the DUT
  logic [31:0] env_mem [NW];
  logic [31:0] ref_mem [NW];
  assign mem_rdata = env_mem[mem_addr[5:2]];
  always @(posedge CLK) if (mem_rw) env_mem[mem_addr[5:2]] <= mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, outcome computed at acceptance
  bit          busy = 0;
  int          phase = 0, lat = 0, wr_ph = 0, m_widx = 0;
  logic        m_err = 0, m_store = 0;
  logic [31:0] m_rdata = 0, m_wdata = 0, m_maddr = 0;
  logic [31:0] last_rdata = 0, last_maddr = 0, last_mwdata = 0;
  logic        last_err = 0;
  logic [31:0] md_waddr, md_old, md_mask, md_lane;
  int          md_off, md_nb, md_shift;

  task automatic finish_txn();
    last_rdata = m_rdata;
    last_err   = m_err;
    if (!m_err) begin
      last_maddr = m_maddr;
      if (m_store) begin
        last_mwdata     = m_wdata;
        ref_mem[m_widx] = m_wdata;
      end
    end
  endtask

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      busy = 0; last_rdata = 0; last_err = 0; last_maddr = 0; last_mwdata = 0;
    end else if (busy) begin
      if (phase == lat) busy = 0;
      else begin
        phase++;
        if (phase == lat) finish_txn();
      end
    end else if (req_valid) begin
      md_off   = int'(req_addr[1:0]);
      md_waddr = req_addr & ~32'h3;
      m_err = (req_size == 2'b11) || (req_size == 2'b01 && md_off % 2 == 1) ||
              (req_size == 2'b10 && md_off != 0);
`ifdef MAU_RANGE_CHECK_EN
      if (64'(md_waddr) + 64'd3 >= 64'(MEM_BYTES)) m_err = 1;
`endif
      m_maddr = md_waddr % MEM_BYTES;
      m_widx  = int'(m_maddr / 4);
      m_store = 0; m_rdata = 0; m_wdata = 0; wr_ph = 0;
      if (m_err) lat = 1;
      else begin
        md_nb    = 1 << req_size;
        md_shift = 8 * (4 - md_nb - md_off);
        md_mask  = (md_nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * md_nb)) - 1);
        md_old   = ref_mem[m_widx];
        if (!req_write) begin
          md_lane = (md_old >> md_shift) & md_mask;
          if (req_signed && md_nb < 4 && md_lane[8*md_nb-1]) md_lane = md_lane | ~md_mask;
          m_rdata = md_lane;
          lat = 2;
        end else begin
          m_store = 1;
          m_wdata = (md_old & ~(md_mask << md_shift)) | ((req_wdata & md_mask) << md_shift);
          lat   = (md_nb == 4) ? 2 : 3;
          wr_ph = lat - 1;
        end
      end
      busy = 1; phase = 1;
      if (lat == 1) finish_txn();
    end
  end

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    check("resp_rdata", resp_rdata, last_rdata);
    check("resp_err", resp_err, last_err);
    if (!busy) begin
      check("ready_idle", req_ready, 1'b1);
      check("valid_idle", resp_valid, 1'b0);
      check("rw_idle", mem_rw, 1'b0);
      check("addr_idle", mem_addr, last_maddr);
      check("wdata_idle", mem_wdata, last_mwdata);
    end else begin
      check("ready_busy", req_ready, 1'b0);
      check("resp_valid", resp_valid, phase == lat);
      check("mem_rw", mem_rw, m_store && phase == wr_ph);
      check("mem_addr", mem_addr, m_err ? last_maddr : m_maddr);
      check("mem_wdata", mem_wdata, (m_store && phase >= wr_ph) ? m_wdata : last_mwdata);
    end
  end

  int          rw_cycles = 0;
  logic [31:0] rw_addr = 0, rw_data = 0;
  always @(negedge CLK) if (mem_rw) begin rw_cycles++; rw_addr = mem_addr; rw_data = mem_wdata; end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, input logic noise,
                        output logic [31:0] rd, output logic er, output int lt);
    int n;
    n = 0; rd = 0; er = 0; lt = 0;
    @(negedge CLK);
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: req_ready got 0, expected 1");
      return;
    end
    #1;
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    #1;
    req_valid = noise;
    if (noise) begin
      req_addr = $urandom; req_wdata = $urandom;
      req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    end
    do begin @(negedge CLK); lt++; end while (!resp_valid && lt < 8);
    req_valid = 0;
    check("resp_seen", resp_valid, 1'b1);
    rd = resp_rdata; er = resp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt, rw0;
    for (int i = 0; i < NW; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'h0123_4567 : (i == 2) ? 32'h8899_AABB : $urandom;
      env_mem[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge CLK);
    #1 Reset = 0;

    do_req(0, 2'b10, 0, 32'h08, 0, 0, rd, er, lt);
    check("wl08_data", rd, 32'h8899_AABB); check("wl08_err", er, 0); check("wl08_lat", lt, 2);
    do_req(0, 2'b00, 1, 32'h09, 0, 0, rd, er, lt);
    check("bl09_s", rd, 32'hFFFF_FF99);
    do_req(0, 2'b00, 0, 32'h09, 0, 0, rd, er, lt);
    check("bl09_u", rd, 32'h0000_0099);
    do_req(0, 2'b01, 1, 32'h0A, 0, 0, rd, er, lt);
    check("hl0a_s", rd, 32'hFFFF_AABB);

    rw0 = rw_cycles;
    do_req(1, 2'b00, 0, 32'h0B, 32'h55, 0, rd, er, lt);
    check("bs0b_lat", lt, 3); check("bs0b_rwcnt", rw_cycles - rw0, 1);
    check("bs0b_addr", rw_addr, 32'h08); check("bs0b_wdata", rw_data, 32'h8899_AA55);
    do_req(0, 2'b10, 0, 32'h08, 0, 0, rd, er, lt);
    check("wl08_after", rd, 32'h8899_AA55);

    rw0 = rw_cycles;
    do_req(0, 2'b10, 0, 32'h06, 0, 0, rd, er, lt);
    check("wl06_err", er, 1); check("wl06_data", rd, 0); check("wl06_lat", lt, 1);
    do_req(1, 2'b01, 0, 32'h03, 32'h1234, 0, rd, er, lt);
    check("hs03_err", er, 1); check("hs03_lat", lt, 1); check("err_rwcnt", rw_cycles - rw0, 0);
    @(negedge CLK); check("err_ready_t2", req_ready, 1);

    do_req(0, 2'b10, 0, 32'h40, 0, 0, rd, er, lt);
`ifdef MAU_RANGE_CHECK_EN
    check("wl40_err", er, 1); check("wl40_data", rd, 0);
`else
    check("wl40_err", er, 0); check("wl40_data", rd, 32'h0123_4567);
`endif

    // Reset during the read phase of a byte store
    @(negedge CLK);
    #1;
    req_valid = 1; req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h08; req_wdata = 32'hEE;
    rw0 = rw_cycles;
    @(posedge CLK);
    #1 req_valid = 0;
    @(negedge CLK);
    #1 Reset = 1;
    @(negedge CLK);
    check("rst_rw", mem_rw, 0); check("rst_valid", resp_valid, 0);
    #1 Reset = 0;
    repeat (2) @(negedge CLK);
    check("rst_ready", req_ready, 1); check("rst_rwcnt", rw_cycles - rw0, 0);
    check("rst_mem", env_mem[2], 32'h8899_AA55);
    do_req(0, 2'b10, 0, 32'h08, 0, 0, rd, er, lt);
    check("rst_reload", rd, 32'h8899_AA55);

    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 75));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, 1'($urandom_range(0, 1)), rd, er, lt);
    end

    repeat (2) @(negedge CLK);
    for (int i = 0; i < NW; i++) check("mem_final", env_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
